// File: rtl/stash_ring_if.sv
// Sample/browse bus of the stash ring: capture and browse controls in, browsed entry and
// occupancy status out.
interface stash_ring_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 5
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] sample_in;
  logic              sample_in_valid;
  logic              next_sample;
  logic              prev_sample;
  logic              clear;
  logic [DATA_W-1:0] sample_out;
  logic [AW-1:0]     browse_idx;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output sample_in, sample_in_valid, next_sample, prev_sample, clear,
    input  sample_out, browse_idx, count, empty, full, overflow
  );

  modport slave (
    input  sample_in, sample_in_valid, next_sample, prev_sample, clear,
    output sample_out, browse_idx, count, empty, full, overflow
  );
endinterface

// File: rtl/stash_ring.sv
// DEPTH-entry ring of captured samples with bidirectional browsing, occupancy flags,
// selectable full policy (overwrite oldest or drop with overflow pulse) and synchronous clear.
module stash_ring #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 5,
  parameter bit          OVERWRITE = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  stash_ring_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic [AW-1:0]     last_idx;
  logic              is_full, is_empty;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LastPtr) ? '0 : p + AW'(1);
  endfunction

  // DEPTH need not be a power of two, so wrap by compare/subtract.
  function automatic logic [AW-1:0] phys_addr(input logic [AW-1:0] base,
                                              input logic [AW-1:0] off);
    logic [AW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= DepthW) sum = sum - DepthW;
    return sum[AW-1:0];
  endfunction

  assign is_full  = (count_q == FullCnt);
  assign is_empty = (count_q == '0);

  always_comb begin
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    count_d  = count_q;
    out_d    = out_q;
    ovf_d    = 1'b0;
    mem_we   = 1'b0;
    last_idx = AW'(count_q - CW'(1));

    if (bus.clear) begin
      head_d   = '0;
      wr_ptr_d = '0;
      idx_d    = '0;
      count_d  = '0;
      out_d    = '0;
    end else if (bus.sample_in_valid) begin
      if (!is_full) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CW'(1);
        idx_d    = AW'(count_q);
        out_d    = bus.sample_in;
      end else if (OVERWRITE) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
        head_d   = ptr_inc(head_q);
        idx_d    = LastPtr;
        out_d    = bus.sample_in;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (!is_empty && (bus.next_sample ^ bus.prev_sample)) begin
      if (bus.next_sample) begin
        idx_d = (idx_q == last_idx) ? '0 : idx_q + AW'(1);
      end else begin
        idx_d = (idx_q == '0) ? last_idx : idx_q - AW'(1);
      end
      out_d = mem_q[phys_addr(head_q, idx_d)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.sample_in;
  end

  assign bus.sample_out = out_q;
  assign bus.browse_idx = idx_q;
  assign bus.count      = count_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
endmodule
